// File: rtl/imem_loader.sv
// Program loader: streams instruction words from the stimuli reader into the
// instruction memory, holds the processor in reset for RST_HOLD cycles and then
// hands the memory read port to the processor fetch path.
module imem_loader #(
  parameter int unsigned          ADDR_W    = 32,
  parameter int unsigned          DATA_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = 'h0040_0000,
  parameter int unsigned          MAX_WORDS = 1024,
  parameter int unsigned          RST_HOLD  = 4
) (
  input  logic                             CLK,
  input  logic                             RST_n,
  input  logic                             start,
  output logic                             stim_en,
  input  logic [DATA_W-1:0]                stim_data,
  input  logic                             stim_eof,
  output logic                             mem_cs,
  output logic                             mem_rd,
  output logic                             mem_wr_n,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [DATA_W-1:0]                mem_din,
  input  logic [DATA_W-1:0]                mem_dout,
  input  logic [ADDR_W-1:0]                dut_pc,
  output logic [DATA_W-1:0]                dut_instr,
  output logic                             dut_rst_n,
  output logic                             done,
  output logic                             err,
  output logic [$clog2(MAX_WORDS+1)-1:0]   word_count
);

  localparam int unsigned CntW  = $clog2(MAX_WORDS + 1);
  localparam int unsigned HoldW = $clog2(RST_HOLD + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StHold, StRun, StErr} state_e;

  state_e            state_q, state_d;
  logic              stim_en_q, stim_en_d;
  logic              pend_q, pend_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              dut_rst_n_q, dut_rst_n_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   wc_q, wc_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic              run;

  // State and registered outputs; reset aborts any load in progress.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= StIdle;
      stim_en_q   <= 1'b0;
      pend_q      <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      dut_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wc_q        <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      stim_en_q   <= stim_en_d;
      pend_q      <= pend_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      dut_rst_n_q <= dut_rst_n_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wc_q        <= wc_d;
      hold_q      <= hold_d;
    end
  end

  // Next-state: load words, detect eof/overflow, count down the reset hold.
  always_comb begin
    state_d     = state_q;
    stim_en_d   = stim_en_q;
    pend_d      = stim_en_q;  // reader answers the cycle after a request
    wr_d        = 1'b0;
    addr_d      = addr_q;
    din_d       = din_q;
    dut_rst_n_d = dut_rst_n_q;
    done_d      = done_q;
    err_d       = err_q;
    wc_d        = wc_q;
    hold_d      = hold_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLoad;
          stim_en_d = 1'b1;
        end
      end
      StLoad: begin
        if (pend_q) begin
          if (stim_eof) begin
            // The request already issued this cycle is left unanswered.
            stim_en_d = 1'b0;
            if (wc_q == '0) begin
              state_d = StErr;
              err_d   = 1'b1;
            end else begin
              state_d = StHold;
              hold_d  = HoldW'(RST_HOLD);
            end
          end else if (wc_q == CntW'(MAX_WORDS)) begin
            stim_en_d = 1'b0;
            state_d   = StErr;
            err_d     = 1'b1;
          end else begin
            wr_d   = 1'b1;
            addr_d = BASE_ADDR + ADDR_W'({wc_q, 2'b00});
            din_d  = stim_data;
            wc_d   = wc_q + 1'b1;
          end
        end
      end
      StHold: begin
        hold_d = hold_q - 1'b1;
        // Leaving on the count of 1 lands RUN entry at RST_HOLD+1 after the last write.
        if (hold_q <= HoldW'(1)) begin
          state_d     = StRun;
          dut_rst_n_d = 1'b1;
          done_d      = 1'b1;
        end
      end
      StRun, StErr: begin
      end
      default: state_d = StIdle;
    endcase
  end

  // Output mux: in RUN the memory port belongs to the processor fetch path.
  always_comb begin
    run       = (state_q == StRun);
    stim_en   = stim_en_q;
    mem_cs    = run | wr_q;
    mem_rd    = run;
    mem_wr_n  = ~(wr_q & ~run);
    mem_addr  = run ? dut_pc : addr_q;
    mem_din   = din_q;
    dut_instr = run ? mem_dout : '0;
    dut_rst_n = dut_rst_n_q;
    done      = done_q;
    err       = err_q;
    word_count = wc_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal load and hold timing, run-phase fetch,
// empty program, reset mid-load, start ignored outside IDLE, and overflow.
module tb_imem_loader;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // DUT A: full-size memory. DUT B: MAX_WORDS=4 for overflow.
  logic        start_a, start_b;
  logic        stim_en_a, stim_en_b;
  logic        mem_cs_a, mem_rd_a, mem_wr_n_a;
  logic        mem_cs_b, mem_rd_b, mem_wr_n_b;
  logic [31:0] mem_addr_a, mem_din_a, mem_dout_a, dut_pc, dut_instr_a;
  logic [31:0] mem_addr_b, mem_din_b, dut_instr_b;
  logic        dut_rst_n_a, done_a, err_a, dut_rst_n_b, done_b, err_b;
  logic [10:0] word_count_a;
  logic [2:0]  word_count_b;

  // Stimuli reader model shared by both DUTs; sel picks whose request it serves.
  logic        sel = 1'b0;
  logic [31:0] stim_data = '0;
  logic        stim_eof = 1'b0;
  int          rd_idx = 0;
  int          prog_n = 0;
  logic [31:0] prog [8];
  logic        stim_en_mux;
  assign stim_en_mux = sel ? stim_en_b : stim_en_a;

  always @(posedge CLK) begin
    if (!stim_en_mux) rd_idx <= 0;
    else if (rd_idx < prog_n) begin
      stim_data <= prog[rd_idx];
      stim_eof  <= 1'b0;
      rd_idx    <= rd_idx + 1;
    end else begin
      stim_data <= '0;
      stim_eof  <= 1'b1;
    end
  end

  // Instruction memory model for DUT A (16 words).
  logic [31:0] mem_a [16];
  always @(posedge CLK) if (mem_cs_a && !mem_wr_n_a) mem_a[mem_addr_a[5:2]] <= mem_din_a;
  assign mem_dout_a = mem_a[mem_addr_a[5:2]];

  imem_loader u_dut_a (
    .CLK(CLK), .RST_n(RST_n), .start(start_a), .stim_en(stim_en_a),
    .stim_data(stim_data), .stim_eof(stim_eof), .mem_cs(mem_cs_a), .mem_rd(mem_rd_a),
    .mem_wr_n(mem_wr_n_a), .mem_addr(mem_addr_a), .mem_din(mem_din_a),
    .mem_dout(mem_dout_a), .dut_pc(dut_pc), .dut_instr(dut_instr_a),
    .dut_rst_n(dut_rst_n_a), .done(done_a), .err(err_a), .word_count(word_count_a)
  );

  imem_loader #(.MAX_WORDS(4)) u_dut_b (
    .CLK(CLK), .RST_n(RST_n), .start(start_b), .stim_en(stim_en_b),
    .stim_data(stim_data), .stim_eof(stim_eof), .mem_cs(mem_cs_b), .mem_rd(mem_rd_b),
    .mem_wr_n(mem_wr_n_b), .mem_addr(mem_addr_b), .mem_din(mem_din_b),
    .mem_dout(32'h0), .dut_pc(32'h0), .dut_instr(dut_instr_b),
    .dut_rst_n(dut_rst_n_b), .done(done_b), .err(err_b), .word_count(word_count_b)
  );

  // Monitors (negedge): write log, reset-release cycle, stim_en rises.
  int unsigned wr_cnt_a = 0, wr_cnt_b = 0, en_rises_a = 0, rise_cyc_a = 0;
  logic [31:0] wr_addr_a [64];
  logic [31:0] wr_data_a [64];
  int unsigned wr_cyc_a  [64];
  logic [31:0] last_addr_b = '0, last_data_b = '0;
  logic        rst_prev_a = 1'b0, en_prev_a = 1'b0;

  always @(negedge CLK) begin
    if (mem_cs_a && !mem_wr_n_a && wr_cnt_a < 64) begin
      wr_addr_a[wr_cnt_a] <= mem_addr_a;
      wr_data_a[wr_cnt_a] <= mem_din_a;
      wr_cyc_a[wr_cnt_a]  <= cyc;
      wr_cnt_a            <= wr_cnt_a + 1;
    end
    if (mem_cs_b && !mem_wr_n_b) begin
      last_addr_b <= mem_addr_b;
      last_data_b <= mem_din_b;
      wr_cnt_b    <= wr_cnt_b + 1;
    end
    if (dut_rst_n_a && !rst_prev_a) rise_cyc_a <= cyc;
    if (stim_en_a && !en_prev_a) en_rises_a <= en_rises_a + 1;
    rst_prev_a <= dut_rst_n_a;
    en_prev_a  <= stim_en_a;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  task automatic wait_end_a(input int bound);
    for (int i = 0; i < bound && !(done_a || err_a); i++) step();
  endtask

  int unsigned base, er;
  int pulsed;

  initial begin
    start_a = 1'b0;
    start_b = 1'b0;
    dut_pc  = '0;
    prog[0] = 32'h0050_0093; prog[1] = 32'h00A0_0113; prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0000_0013; prog[4] = 32'h0010_0073; prog[5] = '0;
    prog[6] = '0; prog[7] = '0;
    repeat (3) step();

    // Reset state
    check_eq("rst_stim_en", stim_en_a, 0);
    check_eq("rst_mem_cs", mem_cs_a, 0);
    check_eq("rst_mem_rd", mem_rd_a, 0);
    check_eq("rst_mem_wr_n", mem_wr_n_a, 1);
    check_eq("rst_mem_addr", mem_addr_a, 0);
    check_eq("rst_mem_din", mem_din_a, 0);
    check_eq("rst_dut_rst_n", dut_rst_n_a, 0);
    check_eq("rst_done_err", {done_a, err_a}, 0);
    check_eq("rst_word_count", word_count_a, 0);
    check_eq("rst_dut_instr", dut_instr_a, 0);
    RST_n = 1'b1;
    step();

    // Three-word load; start pulsed once during HOLD
    prog_n = 3;
    base = wr_cnt_a;
    er = en_rises_a;
    pulse_start_a();
    pulsed = 0;
    for (int i = 0; i < 100 && !(done_a || err_a); i++) begin
      step();
      if (pulsed == 1) begin start_a = 1'b0; pulsed = 2; end
      if (pulsed == 0 && wr_cnt_a == base + 3 && !stim_en_a) begin start_a = 1'b1; pulsed = 1; end
    end
    start_a = 1'b0;
    check_eq("load_finished", done_a, 1);
    check_eq("load_err", err_a, 0);
    check_eq("load_writes", wr_cnt_a - base, 3);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("load_addr%0d", k), wr_addr_a[base+k], 32'h0040_0000 + 4 * k);
      check_eq($sformatf("load_data%0d", k), wr_data_a[base+k], prog[k]);
    end
    check_eq("load_consecutive", wr_cyc_a[base+2] - wr_cyc_a[base], 2);
    check_eq("load_word_count", word_count_a, 3);
    check_eq("hold_release_delay", rise_cyc_a - wr_cyc_a[base+2], 5);
    check_eq("hold_start_ignored", en_rises_a - er, 1);
    check_eq("run_dut_rst_n", dut_rst_n_a, 1);

    // Run-phase fetch
    dut_pc = 32'h0040_0004;
    #1;
    check_eq("fetch_addr", mem_addr_a, 32'h0040_0004);
    check_eq("fetch_instr", dut_instr_a, 32'h00A0_0113);
    check_eq("fetch_strobes", {mem_cs_a, mem_rd_a, mem_wr_n_a}, 3'b111);
    dut_pc = 32'h0040_0008;
    #1;
    check_eq("fetch_instr2", dut_instr_a, 32'h0020_81B3);

    // start during RUN is ignored
    er = en_rises_a;
    pulse_start_a();
    repeat (4) step();
    check_eq("run_start_ignored", en_rises_a - er, 0);
    check_eq("run_still_done", done_a, 1);
    check_eq("run_word_count_held", word_count_a, 3);

    // Empty program
    RST_n = 1'b0; step(); RST_n = 1'b1; step();
    prog_n = 0;
    base = wr_cnt_a;
    pulse_start_a();
    wait_end_a(50);
    repeat (3) step();
    check_eq("empty_err", err_a, 1);
    check_eq("empty_done", done_a, 0);
    check_eq("empty_writes", wr_cnt_a - base, 0);
    check_eq("empty_dut_rst_n", dut_rst_n_a, 0);
    check_eq("empty_word_count", word_count_a, 0);
    check_eq("empty_stim_en", stim_en_a, 0);

    // Reset after two of five words, then reload
    RST_n = 1'b0; step(); RST_n = 1'b1; step();
    prog_n = 5;
    base = wr_cnt_a;
    pulse_start_a();
    for (int i = 0; i < 50 && wr_cnt_a < base + 2; i++) step();
    check_eq("midload_two_writes", wr_cnt_a - base, 2);
    RST_n = 1'b0;
    #1;
    check_eq("midload_rst_stim_en", stim_en_a, 0);
    check_eq("midload_rst_strobes", {mem_cs_a, mem_wr_n_a}, 2'b01);
    check_eq("midload_rst_addr", mem_addr_a, 0);
    check_eq("midload_rst_word_count", word_count_a, 0);
    check_eq("midload_rst_dut_rst_n", dut_rst_n_a, 0);
    step(); step();
    RST_n = 1'b1;
    step(); step();
    prog_n = 3;
    base = wr_cnt_a;
    pulse_start_a();
    wait_end_a(100);
    check_eq("reload_done", done_a, 1);
    check_eq("reload_writes", wr_cnt_a - base, 3);
    check_eq("reload_first_addr", wr_addr_a[base], 32'h0040_0000);
    check_eq("reload_first_data", wr_data_a[base], prog[0]);
    check_eq("reload_word_count", word_count_a, 3);

    // Overflow on the MAX_WORDS=4 instance
    sel = 1'b1;
    prog_n = 5;
    base = wr_cnt_b;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int i = 0; i < 100 && !(done_b || err_b); i++) step();
    repeat (2) step();
    check_eq("ovf_writes", wr_cnt_b - base, 4);
    check_eq("ovf_last_addr", last_addr_b, 32'h0040_000C);
    check_eq("ovf_last_data", last_data_b, prog[3]);
    check_eq("ovf_err_done", {err_b, done_b}, 2'b10);
    check_eq("ovf_word_count", word_count_b, 4);
    check_eq("ovf_dut_rst_n", dut_rst_n_b, 0);
    check_eq("ovf_idle_port", {mem_rd_b, dut_instr_b}, 0);
    check_eq("ovf_stim_en", stim_en_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader and instruction-memory port owner for the RISC-V processor bench.
- Pulls instruction words from the stimuli reader and writes them into the instruction memory at consecutive word addresses.
- Holds the processor in reset for a fixed number of cycles after loading, then releases it.
- In the run phase, hands the instruction-memory read port to the processor fetch path.

Parameters:
- ADDR_W, 32, memory and PC address width.
- DATA_W, 32, instruction word width.
- BASE_ADDR, 32'h0040_0000, byte address of the first loaded word.
- MAX_WORDS, 1024, instruction-memory capacity in words.
- RST_HOLD, 4, cycles that dut_rst_n stays low after loading completes (≥1).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins loading; sampled only in IDLE.
- stim_en  out  1  read request to the stimuli reader.
- stim_data  in  DATA_W  word from the reader, valid the cycle after stim_en was sampled high.
- stim_eof  in  1  end of file, qualified like stim_data.
- mem_cs  out  1  instruction-memory chip select.
- mem_rd  out  1  memory read strobe.
- mem_wr_n  out  1  memory write strobe, active low.
- mem_addr  out  ADDR_W  memory byte address.
- mem_din  out  DATA_W  memory write data.
- mem_dout  in  DATA_W  memory read data.
- dut_pc  in  ADDR_W  processor fetch address.
- dut_instr  out  DATA_W  instruction returned to the processor.
- dut_rst_n  out  1  processor reset, active low.
- done  out  1  loading finished; processor running.
- err  out  1  load failed: empty program or overflow.
- word_count  out  clog2(MAX_WORDS+1)  number of words written.

Behaviour:
- Reset (asynchronous, RST_n=0): state IDLE and all registered outputs cleared: stim_en=0, mem_cs=0, mem_rd=0, mem_wr_n=1, mem_addr=0, mem_din=0, dut_rst_n=0, done=0, err=0, word_count=0, hold counter=0, pend=0.
- Reset during LOAD aborts the load. Memory contents are not cleared.
- IDLE: all memory strobes are inactive. start=1 moves to LOAD on the next edge. start in any other state is ignored.
- LOAD:
  - stim_en=1 every cycle. Register pend = stim_en delayed by one cycle.
  - pend=1 and stim_eof=0: one-cycle write, registered so it appears the next cycle. mem_cs=1, mem_wr_n=0, mem_rd=0, mem_addr=BASE_ADDR+4*word_count, mem_din=stim_data. Then word_count increments.
  - pend=1 and stim_eof=1: stim_en drops the next cycle. If word_count=0, go to ERR. Otherwise go to HOLD and load the hold counter with RST_HOLD. The extra read issued in the eof cycle is ignored.
  - pend=1, stim_eof=0 and word_count=MAX_WORDS: the word is dropped (no write) and the state goes to ERR.
  - Addresses never wrap; overflow detection above prevents it.
- HOLD:
  - Memory strobes are inactive and dut_rst_n=0.
  - The counter decrements each cycle. When it reaches 0, go to RUN.
  - dut_rst_n rises exactly RST_HOLD+1 cycles after the last write strobe.
- RUN:
  - dut_rst_n=1 and done=1 (both registered, asserted on RUN entry).
  - The memory port is combinationally muxed to the processor: mem_cs=1, mem_rd=1, mem_wr_n=1, mem_addr=dut_pc, dut_instr=mem_dout.
  - RUN stays active until reset.
- ERR: err=1, dut_rst_n=0, done=0, stim_en=0, strobes inactive. ERR stays active until reset.
- dut_instr=0 in every state except RUN.
- word_count holds its final value after loading.

Test Plan:
- Load 3 words (0x00500093, 0x00A00113, 0x002081B3), then eof → writes to 0x00400000/04/08 on 3 consecutive cycles; word_count=3; dut_rst_n rises RST_HOLD+1=5 cycles after the last write; done=1.
- RUN fetch → dut_pc=0x00400004 drives mem_addr=0x00400004 the same cycle; mem_dout=0x00A00113 appears on dut_instr combinationally.
- Empty file (eof on first response) → no write strobe, err=1, dut_rst_n stays 0, word_count=0.
- MAX_WORDS=4 with 5 words → 4 writes (last at 0x0040000C), 5th dropped, err=1, done=0.
- RST_n pulsed low after 2 of 5 words → outputs return to reset values immediately; a new start reloads from 0x00400000 with word_count restarting at 0.
- start pulsed during HOLD and RUN → no state change, no extra stim_en.
